// File: rtl/cmp_share_if.sv
// cmp_share_if
// Bundles the requester operand channel, the shared comparator connection and
// the response channel of cmp_share_arbiter.
//   req_valid   [N_REQ]         per-requester operand valid
//   req_data    [N_REQ*DATA_W]  operands, requester i at [i*DATA_W +: DATA_W]
//   req_ready   [N_REQ]         one-hot accept strobe from the arbiter
//   cmp_operand [DATA_W]        operand presented to the shared comparator
//   cmp_result  [1]             comparator output (1 = match)
//   rsp_valid   [1]             response available
//   rsp_id      [ID_W]          index of the requester that owns the response
//   rsp_match   [1]             sampled comparator result
//   rsp_ready   [1]             response consumer accepts
// Modports: slave = arbiter view, master = requesters/comparator/consumer view.
interface cmp_share_if #(
    parameter int N_REQ  = 4,
    parameter int DATA_W = 4,
    parameter int ID_W   = $clog2(N_REQ)
);
    logic [N_REQ-1:0]        req_valid;
    logic [N_REQ*DATA_W-1:0] req_data;
    logic [N_REQ-1:0]        req_ready;
    logic [DATA_W-1:0]       cmp_operand;
    logic                    cmp_result;
    logic                    rsp_valid;
    logic [ID_W-1:0]         rsp_id;
    logic                    rsp_match;
    logic                    rsp_ready;

    modport slave (
        input  req_valid, req_data, cmp_result, rsp_ready,
        output req_ready, cmp_operand, rsp_valid, rsp_id, rsp_match
    );

    modport master (
        output req_valid, req_data, cmp_result, rsp_ready,
        input  req_ready, cmp_operand, rsp_valid, rsp_id, rsp_match
    );
endinterface

// File: rtl/cmp_share_arbiter.sv
// cmp_share_arbiter
// Round-robin arbiter/sequencer sharing one external match comparator among
// N_REQ requesters. One transaction at a time: IDLE (grant + latch operand),
// CMP (comparator sees the latched operand, result captured), RSP (response
// held until accepted).
// Ports:
//   clk        single clock, rising edge
//   rst_n      asynchronous active-low reset
//   bus        cmp_share_if.slave (request, comparator and response signals)
//   hit_clr    (CMP_HIT_COUNT_EN only) synchronous clear of hit_count
//   hit_count  (CMP_HIT_COUNT_EN only) saturating count of matching responses
// Optional feature macro: CMP_HIT_COUNT_EN
module cmp_share_arbiter #(
    parameter int N_REQ  = 4,
    parameter int DATA_W = 4,
    parameter int ID_W   = $clog2(N_REQ)
) (
    input  logic       clk,
    input  logic       rst_n,
    cmp_share_if.slave bus
`ifdef CMP_HIT_COUNT_EN
    ,
    input  logic       hit_clr,
    output logic [7:0] hit_count
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMP  = 2'd1,
        RSP  = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [ID_W-1:0]   last_grant;
    logic [ID_W-1:0]   win;
    logic              any_valid;
    logic              accept;
    logic [N_REQ-1:0]  req_ready_c;
    logic              rsp_valid_c;
    logic [DATA_W-1:0] operand_p0;
    logic [ID_W-1:0]   rsp_id_p1;
    logic              rsp_match_p1;

    // Search starts one past the last grant, so the most recent winner has
    // the lowest priority on the next arbitration.
    always_comb begin : rr_search
        int unsigned     idx;
        logic [ID_W-1:0] cand;
        idx       = 0;
        cand      = '0;
        win       = '0;
        any_valid = 1'b0;
        for (int i = 1; i <= N_REQ; i++) begin
            idx  = (32'(last_grant) + 32'(i)) % 32'(N_REQ);
            cand = ID_W'(idx);
            if (!any_valid && bus.req_valid[cand]) begin
                win       = cand;
                any_valid = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        req_ready_c = '0;
        rsp_valid_c = 1'b0;
        unique case (state)
            IDLE: begin
                if (any_valid) begin
                    req_ready_c = N_REQ'(1) << win;
                    state_nxt   = CMP;
                end
            end
            CMP: begin
                state_nxt = RSP;
            end
            RSP: begin
                rsp_valid_c = 1'b1;
                if (bus.rsp_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // The winner is always a valid requester, so any grant is an accept.
    assign accept = (state == IDLE) && any_valid;

    // Stage p0: operand latched at accept, held until the next accept
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant <= ID_W'(N_REQ - 1);
            operand_p0 <= '0;
        end else if (accept) begin
            last_grant <= win;
            operand_p0 <= bus.req_data[32'(win) * DATA_W +: DATA_W];
        end
    end

    // Stage p1: comparator result and owner captured at the end of CMP
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_id_p1    <= '0;
            rsp_match_p1 <= 1'b0;
        end else if (state == CMP) begin
            rsp_id_p1    <= last_grant;
            rsp_match_p1 <= bus.cmp_result;
        end
    end

    assign bus.req_ready   = req_ready_c;
    assign bus.cmp_operand = operand_p0;
    assign bus.rsp_valid   = rsp_valid_c;
    assign bus.rsp_id      = rsp_id_p1;
    assign bus.rsp_match   = rsp_match_p1;

`ifdef CMP_HIT_COUNT_EN
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    // Clear wins over a same-cycle matching handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_count <= 8'd0;
        end else if (hit_clr) begin
            hit_count <= 8'd0;
        end else if ((state == RSP) && bus.rsp_ready && rsp_match_p1) begin
            hit_count <= sat_inc8(hit_count);
        end
    end
`endif

endmodule
